// File: rtl/uart_tx_bus_if.sv
// uart_tx_bus_if: the core data bus as seen by a memory-mapped slave.
// Carries the byte address, write data and byte strobes, single-cycle read and
// write requests, and the registered read data that comes back.
`timescale 1ns/1ps

interface uart_tx_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  // The core drives requests and samples read data.
  modport master (
    output addr, wdata, re, we, wstrb,
    input  rdata
  );

  // The peripheral samples requests and returns read data.
  modport slave (
    input  addr, wdata, re, we, wstrb,
    output rdata
  );
endinterface

// File: rtl/uart_tx_bus.sv
// uart_tx_bus: memory-mapped UART transmitter sitting beside the data RAM.
// The core pushes bytes into a TX FIFO through TXDATA. It reads STATUS and
// BAUDDIV over the same bus. A serializer drains the FIFO onto tx as 8N1
// frames, with each bit held for BAUDDIV+1 clocks.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. When it is set, STATUS bit4 reads 1.
`timescale 1ns/1ps

module uart_tx_bus #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic            clk,
  input  logic            rst,   // asynchronous, active low
  uart_tx_bus_if.slave    bus,
  output logic            tx,
  output logic            irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_BAUD   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        w_sel;
  reg_e        w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_baud_wr;

  assign w_sel      = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = reg_e'(bus.addr[3:2]);
  assign w_wr       = bus.we & w_sel;
  assign w_rd       = bus.re & w_sel;
  assign w_push_req = w_wr & (w_off == REG_TXDATA) & bus.wstrb[0];
  assign w_ovf_clr  = w_wr & (w_off == REG_STATUS) & bus.wstrb[0] & bus.wdata[3];
  assign w_baud_wr  = w_wr & (w_off == REG_BAUD);

  // Bus bits that carry no information for this block.
  logic w_unused;
  assign w_unused = ^{bus.addr[1:0], bus.wdata[31:16], bus.wstrb[3:2]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [7:0]    w_head;

  // Full is taken from the registered count, so a push into a full FIFO is
  // dropped even if the serializer pops in the same cycle.
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = w_push_req & ~w_full;
  assign w_ovf_set = w_push_req &  w_full;
  assign w_head    = r_mem[r_rd_ptr];

  // Storage array: the write pointer places each accepted byte.
  // NOTE: the data array has no reset; only the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wdata[7:0];
  end

  // Pointers wrap naturally modulo FIFO_DEPTH; the count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic        r_ovf;
  logic [15:0] r_baud;

  // Sticky overflow flag. A set and a clear cannot coincide because they
  // decode different offsets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // Baud divisor with byte-lane writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud <= DEFAULT_DIV;
    end else if (w_baud_wr) begin
      if (bus.wstrb[0]) r_baud[7:0]  <= bus.wdata[7:0];
      if (bus.wstrb[1]) r_baud[15:8] <= bus.wdata[15:8];
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_div;       // divisor latched for the frame in flight
  logic [15:0] r_cnt;       // clocks left in the current bit, minus one
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic        r_tx;
  logic        w_bit_done;
  logic        w_load;      // pop the head and start a new frame
  logic        w_reload;    // current bit finished, start the next one
  logic        w_shift;     // advance to the next data bit
  logic        w_tx_lvl;
  logic        w_busy;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_bit_done = (r_cnt == '0);
  assign w_busy     = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, line level and datapath strobes. When STOP ends with a byte
  // waiting, the FSM goes straight to START so that frames stay contiguous.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_reload    = 1'b0;
    w_shift     = 1'b0;
    w_tx_lvl    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_lvl = 1'b0;
        if (w_bit_done) begin
          w_reload    = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_lvl = r_shift[0];
        if (w_bit_done) begin
          w_reload = 1'b1;
          w_shift  = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_lvl = r_parity;
        if (w_bit_done) begin
          w_reload    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_tx_lvl = 1'b1;
        if (w_bit_done) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timer, shift register and registered line driver. tx follows the
  // state by one clock, and it is forced high asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_lvl;
      if (w_load) begin
        r_div     <= r_baud;
        r_cnt     <= r_baud;
        r_shift   <= w_head;
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= ^w_head;
`endif
      end else if (w_reload) begin
        r_cnt <= r_div;
        if (w_shift) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else if (w_busy) begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

  assign tx  = r_tx;
  assign irq = w_empty & ~w_busy;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] w_status;
  logic [31:0] w_rd_val;
  logic [31:0] r_rdata;

  // STATUS word assembly.
  always_comb begin
    w_status           = '0;
    w_status[0]        = w_full;
    w_status[1]        = w_empty;
    w_status[2]        = w_busy;
    w_status[3]        = r_ovf;
    w_status[4]        = PARITY_FLAG;
    w_status[8 +: CW]  = r_count;
  end

  // Register read mux; TXDATA and the reserved slot read as zero.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      REG_STATUS: w_rd_val = w_status;
      REG_BAUD:   w_rd_val = {16'b0, r_baud};
      default:    w_rd_val = '0;
    endcase
  end

  // Read data is valid for the single cycle that follows a read and is zero
  // at all other times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rd_val;
    else           r_rdata <= '0;
  end

  assign bus.rdata = r_rdata;

endmodule
